// File: rtl/cpu6_pipestage_skid.sv
// cpu6_pipestage_skid
//   Generic valid/ready pipeline-stage register with a 2-entry skid buffer.
//   Replaces the hand-written per-signal inter-stage registers (ID/EX etc.):
//   the caller concatenates its control/data fields into one payload vector.
//   The skid entry lets in_ready be a pure register output and still sustain
//   one transfer per cycle.
//
// Parameters
//   WIDTH        payload width in bits
//   ZERO_BUBBLE  1: out_data reads all-zero (NOP) whenever out_valid=0
//   RESET_DATA   value loaded into both payload registers on reset/flush
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset (wins over flush)
//   flush      synchronous kill of every held entry
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered, = ~skid_valid)
//   in_data    upstream payload
//   out_valid  downstream payload valid (= main_valid)
//   out_ready  downstream accepts
//   out_data   downstream payload
//
// Optional build macro CPU6_PIPESTAGE_PERF_EN adds saturating counters:
//   stall_cnt   cycles with out_valid & ~out_ready
//   bubble_cnt  cycles with ~out_valid
//   flush_cnt   flush cycles while the stage held anything
//   They clear on reset only; flush leaves them alone.

module cpu6_pipestage_skid #(
   parameter int               WIDTH       = 64,
   parameter bit               ZERO_BUBBLE = 1'b1,
   parameter logic [WIDTH-1:0] RESET_DATA  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef CPU6_PIPESTAGE_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      bubble_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   // Bit 0 is main_valid, bit 1 is skid_valid; 2'b10 (skid without main)
   // is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_data, skid_data;
   logic             main_valid, skid_valid;
   logic             in_fire, out_fire;
   logic             main_ld_in, main_ld_skid, skid_ld;

   assign main_valid = state[0];
   assign skid_valid = state[1];

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   // Next-state and payload-load decode. Reset/flush override in the
   // register process, so this only describes the normal handshake.
   always_comb begin
      state_nxt    = state;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt  = ST_BUSY;
               main_ld_in = 1'b1;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_ld_in = 1'b1;
            end else if (in_fire) begin
               // Downstream stalled: park the new entry behind main.
               state_nxt = ST_FULL;
               skid_ld   = 1'b1;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_fire) begin
               state_nxt    = ST_BUSY;
               main_ld_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         // An in_fire in a flush cycle is acknowledged but its payload dropped.
         state     <= ST_EMPTY;
         main_data <= RESET_DATA;
         skid_data <= RESET_DATA;
      end else begin
         state <= state_nxt;
         if (main_ld_in)
            main_data <= in_data;
         else if (main_ld_skid)
            main_data <= skid_data;
         if (skid_ld)
            skid_data <= in_data;
      end
   end

   // Masking is output-only so the registers keep their contents; it also
   // keeps unknown upstream data from leaking while the slot is empty.
   generate
      if (ZERO_BUBBLE) begin : g_zero
         assign out_data = main_valid ? main_data : '0;
      end else begin : g_raw
         assign out_data = main_data;
      end
   endgenerate

`ifdef CPU6_PIPESTAGE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (!main_valid && bubble_cnt != 32'hFFFF_FFFF)
            bubble_cnt <= bubble_cnt + 32'd1;
         if (flush && (main_valid || skid_valid) && flush_cnt != 32'hFFFF_FFFF)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu6_pipestage_skid.sv
// Bench for cpu6_pipestage_skid: a queue scoreboard receives every accepted
// payload and is compared against the DUT on the falling edge of each cycle.
// A second instance (ZERO_BUBBLE=0, RESET_DATA=5) covers the unmasked output.

module tb_cpu6_pipestage_skid;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [63:0] in_data;
   logic        in_ready, out_valid;
   logic [63:0] out_data;

   logic        flush2, in_valid2, out_ready2;
   logic [63:0] in_data2;
   logic        in_ready2, out_valid2;
   logic [63:0] out_data2;

`ifdef CPU6_PIPESTAGE_PERF_EN
   logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
   logic [31:0] stall_cnt2, bubble_cnt2, flush_cnt2;
   int          m_stall, m_bubble, m_flush;
`endif

   int          n_chk = 0;
   int          n_pass = 0;
   bit          started = 1'b0;
   logic [63:0] q[$];
   bit          exp_valid, exp_ready;

   always #5 clk = ~clk;

   cpu6_pipestage_skid #(.WIDTH(64), .ZERO_BUBBLE(1'b1), .RESET_DATA(64'h0)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef CPU6_PIPESTAGE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
   );

   cpu6_pipestage_skid #(.WIDTH(64), .ZERO_BUBBLE(1'b0), .RESET_DATA(64'h5)) dut2 (
      .clk(clk), .reset(reset), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef CPU6_PIPESTAGE_PERF_EN
      , .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
   endtask

   // Scoreboard: compare state as it stands before the coming edge, then
   // advance the model by what that edge will do.
   always @(negedge clk) begin
      if (started) begin
         exp_valid = (q.size() != 0);
         exp_ready = (q.size() < 2);
         chk("out_valid", out_valid, exp_valid);
         chk("in_ready", in_ready, exp_ready);
         chk("out_data", out_data, exp_valid ? q[0] : 64'h0);
`ifdef CPU6_PIPESTAGE_PERF_EN
         chk("stall_cnt", stall_cnt, m_stall);
         chk("bubble_cnt", bubble_cnt, m_bubble);
         chk("flush_cnt", flush_cnt, m_flush);
`endif
         if (reset) begin
            q.delete();
`ifdef CPU6_PIPESTAGE_PERF_EN
            m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
         end else begin
`ifdef CPU6_PIPESTAGE_PERF_EN
            if (exp_valid && !out_ready) m_stall++;
            if (!exp_valid) m_bubble++;
            if (flush && exp_valid) m_flush++;
`endif
            if (flush) begin
               q.delete();
            end else begin
               if (exp_valid && out_ready) void'(q.pop_front());
               if (in_valid && exp_ready) q.push_back(in_data);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef CPU6_PIPESTAGE_PERF_EN
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
      @(posedge clk);
      started = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Unmasked instance: reset value, then a payload left behind after draining.
      chk("zb0_rst_data", out_data2, 64'h5);
      chk("zb0_rst_valid", out_valid2, 1'b0);
      in_valid2 = 1'b1; in_data2 = 64'h77; out_ready2 = 1'b1;
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      in_valid2 = 1'b0; in_data2 = 64'h0;
      chk("zb0_load_valid", out_valid2, 1'b1);
      chk("zb0_load_data", out_data2, 64'h77);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      chk("zb0_empty_valid", out_valid2, 1'b0);
      chk("zb0_empty_data", out_data2, 64'h77);
      chk("zb0_empty_ready", in_ready2, 1'b1);

      // Back-to-back stream at full rate.
      for (int i = 1; i <= 8; i++) drive(1'b1, 64'(i), 1'b1, 1'b0);
      repeat (2) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Fill to FULL under a stall, hold, then drain A then B.
      drive(1'b1, 64'hAA, 1'b0, 1'b0);
      drive(1'b1, 64'hBB, 1'b0, 1'b0);
      repeat (2) drive(1'b0, 64'h0, 1'b0, 1'b0);
      repeat (3) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Flush while FULL with C offered: nothing survives.
      drive(1'b1, 64'h11, 1'b0, 1'b0);
      drive(1'b1, 64'h22, 1'b0, 1'b0);
      drive(1'b1, 64'hCC, 1'b0, 1'b1);
      repeat (2) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Flush in BUSY with simultaneous out_fire and in_fire.
      drive(1'b1, 64'h33, 1'b0, 1'b0);
      drive(1'b1, 64'h44, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Reset while FULL.
      drive(1'b1, 64'h55, 1'b0, 1'b0);
      drive(1'b1, 64'h66, 1'b0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (2) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));

      repeat (4) drive(1'b0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
